// File: rtl/router_pkg.sv
// Shared types and constants for the router input-side write controller.
// State encoding is fixed so neighbouring blocks and debug probes agree on values.
package router_pkg;

    localparam int          ADDR_W       = 2;
    localparam logic [1:0]  INVALID_ADDR = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet write sequencer: decodes the destination from the header byte and
// steps header, payload and parity writes into the selected router FIFO.
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 3
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 busy
);

    localparam int SEL_W = 1 << ADDR_W;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;

    // Flags padded to the full address range so the invalid address reads as 0.
    logic [SEL_W-1:0] empty_ext;
    logic [SEL_W-1:0] soft_ext;

    assign empty_ext = {{(SEL_W-NUM_PORTS){1'b0}}, fifo_empty};
    assign soft_ext  = {{(SEL_W-NUM_PORTS){1'b0}}, soft_reset};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= DECODE_ADDRESS;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE_ADDRESS && pkt_valid)
                addr_reg <= data_in;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DECODE_ADDRESS: begin
                if (pkt_valid && data_in != INVALID_ADDR)
                    state_next = empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_next = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_next = LOAD_PARITY;
            end
            LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_next = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_next = LOAD_PARITY;
                else
                    state_next = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_ext[addr_reg])
                    state_next = LOAD_FIRST_DATA;
            end
            default: state_next = DECODE_ADDRESS;
        endcase

        // A timed-out FIFO abandons the packet from anywhere past address decode.
        if (state_reg != DECODE_ADDRESS && soft_ext[addr_reg])
            state_next = DECODE_ADDRESS;
    end

    assign detect_add    = (state_reg == DECODE_ADDRESS);
    assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
    assign ld_state      = (state_reg == LOAD_DATA);
    assign laf_state     = (state_reg == LOAD_AFTER_FULL);
    assign full_state    = (state_reg == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_reg == LOAD_FIRST_DATA) || (state_reg == LOAD_DATA) ||
                           (state_reg == LOAD_PARITY)     || (state_reg == LOAD_AFTER_FULL);
    assign busy          = !((state_reg == DECODE_ADDRESS) || (state_reg == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm; the state is identified from the output
// signature {detect,lfd,ld,laf,full,rst_int,busy,write_enb}.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [7:0] sig;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] S_DA  = 8'b1000_0000;
    localparam logic [7:0] S_LFD = 8'b0100_0011;
    localparam logic [7:0] S_LD  = 8'b0010_0001;
    localparam logic [7:0] S_LP  = 8'b0000_0011;
    localparam logic [7:0] S_FFS = 8'b0000_1010;
    localparam logic [7:0] S_LAF = 8'b0001_0011;
    localparam logic [7:0] S_WTE = 8'b0000_0010;
    localparam logic [7:0] S_CPE = 8'b0000_0110;

    router_fsm #(.NUM_PORTS(3)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    assign sig = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  rst_int_reg, busy, write_enb_reg};

    // Advance one rising edge; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        step();
        total++;
        if (sig !== S_DA) begin bad++; $display("FAIL reset_state: got %b expected %b", sig, S_DA); end
        resetn = 1'b1;
        step();
        total++;
        if (sig !== S_DA) begin bad++; $display("FAIL idle_after_reset: got %b expected %b", sig, S_DA); end
        $display("test_reset: sig=%b", sig);
    endtask

    task automatic test_async_reset();
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b111;
        step();
        step();
        total++;
        if (sig !== S_LD) begin bad++; $display("FAIL async_setup_ld: got %b expected %b", sig, S_LD); end
        #1 resetn = 1'b0;
        #1;
        total++;
        if (sig !== S_DA) begin bad++; $display("FAIL async_reset_immediate: got %b expected %b", sig, S_DA); end
        pkt_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        step();
        total++;
        if (sig !== S_DA) begin bad++; $display("FAIL async_release: got %b expected %b", sig, S_DA); end
        $display("test_async_reset: sig=%b", sig);
    endtask

    task automatic test_packet();
        fifo_empty = 3'b111; pkt_valid = 1'b1; data_in = 2'd1;
        step();
        total++;
        if (sig !== S_LFD) begin bad++; $display("FAIL pkt_lfd: got %b expected %b", sig, S_LFD); end
        for (int i = 0; i < 14; i++) begin
            step();
            total++;
            if (sig !== S_LD) begin bad++; $display("FAIL pkt_ld[%0d]: got %b expected %b", i, sig, S_LD); end
        end
        pkt_valid = 1'b0;
        step();
        total++;
        if (sig !== S_LP) begin bad++; $display("FAIL pkt_lp: got %b expected %b", sig, S_LP); end
        step();
        total++;
        if (sig !== S_CPE) begin bad++; $display("FAIL pkt_cpe: got %b expected %b", sig, S_CPE); end
        step();
        total++;
        if (sig !== S_DA) begin bad++; $display("FAIL pkt_da: got %b expected %b", sig, S_DA); end
        $display("test_packet: 14 payload cycles, sig=%b", sig);
    endtask

    task automatic test_wait();
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (sig !== S_WTE) begin bad++; $display("FAIL wait_wte[%0d]: got %b expected %b", i, sig, S_WTE); end
        end
        fifo_empty = 3'b111;
        step();
        total++;
        if (sig !== S_LFD) begin bad++; $display("FAIL wait_lfd: got %b expected %b", sig, S_LFD); end
        step();
        total++;
        if (sig !== S_LD) begin bad++; $display("FAIL wait_ld: got %b expected %b", sig, S_LD); end
        $display("test_wait: sig=%b", sig);
    endtask

    // Continues from LOAD_DATA left by test_wait.
    task automatic test_full();
        fifo_full = 1'b1;
        step();
        total++;
        if (sig !== S_FFS) begin bad++; $display("FAIL full_enter: got %b expected %b", sig, S_FFS); end
        step();
        total++;
        if (sig !== S_FFS) begin bad++; $display("FAIL full_hold: got %b expected %b", sig, S_FFS); end
        fifo_full = 1'b0;
        step();
        total++;
        if (sig !== S_LAF) begin bad++; $display("FAIL full_laf1: got %b expected %b", sig, S_LAF); end
        step();
        total++;
        if (sig !== S_LD) begin bad++; $display("FAIL laf_to_ld: got %b expected %b", sig, S_LD); end
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        step();
        total++;
        if (sig !== S_LAF) begin bad++; $display("FAIL full_laf2: got %b expected %b", sig, S_LAF); end
        low_pkt_valid = 1'b1;
        step();
        total++;
        if (sig !== S_LP) begin bad++; $display("FAIL laf_to_lp: got %b expected %b", sig, S_LP); end
        low_pkt_valid = 1'b0; fifo_full = 1'b1;
        step();
        total++;
        if (sig !== S_CPE) begin bad++; $display("FAIL lp_to_cpe: got %b expected %b", sig, S_CPE); end
        step();
        total++;
        if (sig !== S_FFS) begin bad++; $display("FAIL cpe_to_full: got %b expected %b", sig, S_FFS); end
        fifo_full = 1'b0;
        step();
        parity_done = 1'b1; low_pkt_valid = 1'b1;
        step();
        total++;
        if (sig !== S_DA) begin bad++; $display("FAIL laf_parity_done_priority: got %b expected %b", sig, S_DA); end
        parity_done = 1'b0; low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        step();
        $display("test_full: sig=%b", sig);
    endtask

    task automatic test_invalid_addr();
        fifo_empty = 3'b111; pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (sig !== S_DA) begin bad++; $display("FAIL invalid_addr[%0d]: got %b expected %b", i, sig, S_DA); end
        end
        pkt_valid = 1'b0;
        step();
        $display("test_invalid_addr: sig=%b", sig);
    endtask

    task automatic test_soft_reset();
        fifo_empty = 3'b110; pkt_valid = 1'b1; data_in = 2'd0;
        step();
        total++;
        if (sig !== S_WTE) begin bad++; $display("FAIL soft_setup_wte: got %b expected %b", sig, S_WTE); end
        pkt_valid = 1'b0; soft_reset = 3'b001;
        step();
        total++;
        if (sig !== S_DA) begin bad++; $display("FAIL soft_reset_hit: got %b expected %b", sig, S_DA); end
        soft_reset = 3'b000; pkt_valid = 1'b1;
        step();
        // Address latch must hold 0 even though data_in now points at an empty FIFO.
        pkt_valid = 1'b1; data_in = 2'd2; soft_reset = 3'b010;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (sig !== S_WTE) begin bad++; $display("FAIL soft_reset_other[%0d]: got %b expected %b", i, sig, S_WTE); end
        end
        pkt_valid = 1'b0; soft_reset = 3'b001;
        step();
        total++;
        if (sig !== S_DA) begin bad++; $display("FAIL soft_reset_again: got %b expected %b", sig, S_DA); end
        soft_reset = 3'b000;
        $display("test_soft_reset: sig=%b", sig);
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_packet();
        test_wait();
        test_full();
        test_invalid_addr();
        test_soft_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
